pdm_tx: RTL and testbench
=========================

# pdm_tx

PDM transmitter: accepts signed PCM samples over a valid/ready stream, buffers them in a small FIFO, and emits a 1-bit PDM stream plus its bit clock using a first-order sigma-delta modulator. It is the transmit end of the microphone interface that wakey_wakey receives on its PDM data and clock pins. It serves as an on-chip stimulus source and loopback driver for that input path.

## Interface

Parameters:
- PCM_BW, 16, PCM sample width (signed two's complement)
- OSR, 64, PDM bits emitted per PCM sample (power of 2, ≥2)
- HALF_DIV, 4, clk_i cycles per pdm_clk_o half-period (≥2)
- FIFO_DEPTH, 4, sample FIFO entries (power of 2)

Ports:
- clk_i  input  1  system clock
- rst_n_i  input  1  reset; one clock; reset is asynchronous and active-low
- enable_i  input  1  run modulator and clock output
- pcm_data_i  input  PCM_BW  signed sample
- pcm_valid_i  input  1  sample valid
- pcm_ready_o  output  1  FIFO can accept (= not full)
- pdm_clk_o  output  1  PDM bit clock; receiver samples on rising edge
- pdm_data_o  output  1  PDM bit
- underflow_o  output  1  one-cycle pulse: FIFO empty when a new sample was needed

## Operation

- Reset values: pdm_clk_o=0, pdm_data_o=0, underflow_o=0, pcm_ready_o=1, FIFO empty, accumulator 0, state IDLE.
- FIFO: push when pcm_valid_i && pcm_ready_o, regardless of enable_i. pcm_ready_o = !full from registered count; a pop in the same cycle does not make a full FIFO accept. Simultaneous push and pop on a non-full FIFO leaves the count unchanged.
- Modulator: u = x with MSB inverted, giving an unsigned offset of x + 2^(PCM_BW-1). The accumulator acc is PCM_BW bits unsigned. sum = acc + u is PCM_BW+1 bits. The output bit is sum[PCM_BW], and acc takes sum[PCM_BW-1:0]. The density of ones is u/2^PCM_BW.
- States:
  - IDLE: pdm_clk_o=0, pdm_data_o=0, acc=0, divider=0, bit counter=0.
    - enable_i=1 moves to LOAD.
  - LOAD (1 cycle): the current-sample register takes the FIFO head and pops it.
    - If the FIFO is empty, the current sample becomes 0 and underflow_o pulses.
    - Bit 0 is registered onto pdm_data_o at the end of the cycle.
    - Moves to RUN.
  - RUN: pdm_clk_o is low for HALF_DIV cycles, then high for HALF_DIV cycles, repeating.
    - On every high→low transition, the next bit is registered in the same cycle that pdm_clk_o falls.
    - After OSR bits of a sample, the falling edge that emits the next bit 0 also pops the FIFO.
    - If the FIFO is empty at that point, the current sample is reused and underflow_o pulses.
- enable_i=0 in any state: the next state is IDLE and the outputs are 0 on the next cycle. The in-flight sample is discarded, and FIFO contents are kept.
- Re-enabling restarts from LOAD with acc=0.

## Timing

- pdm_clk_o period is 2·HALF_DIV clk_i cycles with 50% duty. The first rising edge occurs HALF_DIV cycles after LOAD.
- pdm_data_o is stable for the full 2·HALF_DIV cycles around each rising edge. It changes only coincident with a falling edge, or at the end of LOAD.
- Latency: from enable_i high with a non-empty FIFO, the first bit is on pdm_data_o 2 cycles later (IDLE→LOAD, registered output).
- One PCM sample is consumed every OSR·2·HALF_DIV cycles in steady state.
- Reset asserted mid-operation clears everything immediately. This is asynchronous; no partial bit is emitted.

## Configuration

- PDM_TX_UNDERFLOW_CNT_EN defined: adds output underflow_cnt_o [7:0].
  - The counter increments on each underflow_o pulse and saturates at 255.
  - It is cleared only by reset.
- PDM_TX_UNDERFLOW_CNT_EN undefined: the port and counter are absent. All other behaviour is identical.

## Test plan

- Reset: assert rst_n_i low mid-RUN → all outputs 0 within the same cycle, pcm_ready_o=1, FIFO empty after release.
- Push x=0, enable (OSR=64, HALF_DIV=4) → pdm_clk_o period 8 cycles; bits sampled at rising edges read 0,1,0,1,…; no underflow during the first 64 bits.
- Push x=0x8000 then x=0x7FFF → the first 64 bits are all 0. The next 64 bits are 0 followed by 63 ones; acc is not cleared between samples, so the first bit depends on acc carried over.
- With enable_i=0, push 5 samples → pcm_ready_o drops after the 4th accept and the 5th stalls. Enable → ready returns 1 the cycle after the LOAD pop.
- Push only x=0x4000 and enable → the bit pattern is 0,1,1,1 repeating. After 64 bits underflow_o pulses exactly once, and the pattern continues, with another pulse every 64 bits. With the macro defined, underflow_cnt_o increments accordingly.
- Drop enable_i mid-sample → pdm_clk_o=0 and pdm_data_o=0 on the next cycle. Re-enable → the next FIFO sample starts with acc=0, and the in-flight sample does not resume.

Source files
------------

// File: rtl/pdm_tx.sv
// PDM transmitter: PCM stream -> sample FIFO -> first-order sigma-delta -> 1-bit PDM + bit clock.
// Optional PDM_TX_UNDERFLOW_CNT_EN adds a saturating underflow counter output (underflow_cnt_o).
//
// state | meaning
// IDLE  | outputs low, accumulator/divider/bit counter cleared, waiting for enable_i
// LOAD  | one cycle: pop FIFO head (or 0 on underflow), register bit 0
// RUN   | toggle pdm_clk_o every HALF_DIV cycles, emit next bit on each falling edge
module pdm_tx #(
  parameter int PCM_BW     = 16,
  parameter int OSR        = 64,
  parameter int HALF_DIV   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              enable_i,
  input  logic [PCM_BW-1:0] pcm_data_i,
  input  logic              pcm_valid_i,
  output logic              pcm_ready_o,
  output logic              pdm_clk_o,
  output logic              pdm_data_o,
  output logic              underflow_o
`ifdef PDM_TX_UNDERFLOW_CNT_EN
  ,
  output logic [7:0]        underflow_cnt_o
`endif
);

  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int BCW = $clog2(OSR);
  localparam int DCW = $clog2(HALF_DIV);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t state_q, state_d;

  logic [PCM_BW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              fifo_full, fifo_empty, push, pop, pop_eff;
  logic [PCM_BW-1:0] fifo_head;

  logic [PCM_BW-1:0] acc_q, acc_d, smp_q, smp_d;
  logic [DCW-1:0]    div_q, div_d;
  logic [BCW-1:0]    bit_q, bit_d;
  logic              clk_q, clk_d, data_q, data_d, uf_q, uf_d;
  logic [PCM_BW:0]   sum;

  // Offset-binary view of the sample added to the accumulator; carry out is the PDM bit.
  function automatic logic [PCM_BW:0] mod_sum(input logic [PCM_BW-1:0] a,
                                               input logic [PCM_BW-1:0] x);
    return {1'b0, a} + {1'b0, ~x[PCM_BW-1], x[PCM_BW-2:0]};
  endfunction

  assign fifo_full   = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty  = (count_q == '0);
  assign fifo_head   = mem[rd_ptr_q];
  assign push        = pcm_valid_i && !fifo_full;
  assign pop_eff     = pop && !fifo_empty;
  assign pcm_ready_o = !fifo_full;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= pcm_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)    wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_eff) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop_eff})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      smp_q   <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      clk_q   <= 1'b0;
      data_q  <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      smp_q   <= smp_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      clk_q   <= clk_d;
      data_q  <= data_d;
      uf_q    <= uf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    smp_d   = smp_q;
    div_d   = div_q;
    bit_d   = bit_q;
    clk_d   = clk_q;
    data_d  = data_q;
    uf_d    = 1'b0;
    pop     = 1'b0;
    sum     = '0;
    if (!enable_i) begin
      state_d = IDLE;
      acc_d   = '0;
      div_d   = '0;
      bit_d   = '0;
      clk_d   = 1'b0;
      data_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = LOAD;
        LOAD: begin
          pop     = 1'b1;
          smp_d   = fifo_empty ? '0 : fifo_head;
          uf_d    = fifo_empty;
          sum     = mod_sum('0, smp_d);
          acc_d   = sum[PCM_BW-1:0];
          data_d  = sum[PCM_BW];
          bit_d   = '0;
          div_d   = DCW'(HALF_DIV - 1);
          clk_d   = 1'b0;
          state_d = RUN;
        end
        RUN: begin
          if (div_q == '0) begin
            div_d = DCW'(HALF_DIV - 1);
            clk_d = !clk_q;
            // Falling edge of the bit clock: emit the next bit, rolling to a new sample after OSR bits.
            if (clk_q) begin
              if (bit_q == BCW'(OSR - 1)) begin
                pop   = 1'b1;
                bit_d = '0;
                if (!fifo_empty) smp_d = fifo_head;
                else             uf_d  = 1'b1;
              end else begin
                bit_d = bit_q + BCW'(1);
              end
              sum    = mod_sum(acc_q, smp_d);
              acc_d  = sum[PCM_BW-1:0];
              data_d = sum[PCM_BW];
            end
          end else begin
            div_d = div_q - DCW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign pdm_clk_o   = clk_q;
  assign pdm_data_o  = data_q;
  assign underflow_o = uf_q;

`ifdef PDM_TX_UNDERFLOW_CNT_EN
  logic [7:0] uf_cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                       uf_cnt_q <= '0;
    else if (uf_q && uf_cnt_q != 8'hFF) uf_cnt_q <= uf_cnt_q + 8'd1;
  end

  assign underflow_cnt_o = uf_cnt_q;
`endif

endmodule

// File: tb/tb_pdm_tx.sv
// Self-checking bench for pdm_tx: bit-level sigma-delta model checked at every pdm_clk_o rising edge,
// plus directed literal expectations for patterns, timing, backpressure, underflow and reset.
module tb_pdm_tx;
  localparam int PCM_BW     = 16;
  localparam int OSR        = 64;
  localparam int HALF_DIV   = 4;
  localparam int FIFO_DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_n_i, enable_i, pcm_valid_i;
  logic [15:0] pcm_data_i;
  logic        pcm_ready_o, pdm_clk_o, pdm_data_o, underflow_o;
`ifdef PDM_TX_UNDERFLOW_CNT_EN
  logic [7:0]  underflow_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  pdm_tx #(.PCM_BW(PCM_BW), .OSR(OSR), .HALF_DIV(HALF_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_i(clk_i),
    .rst_n_i(rst_n_i),
    .enable_i(enable_i),
    .pcm_data_i(pcm_data_i),
    .pcm_valid_i(pcm_valid_i),
    .pcm_ready_o(pcm_ready_o),
    .pdm_clk_o(pdm_clk_o),
    .pdm_data_o(pdm_data_o),
    .underflow_o(underflow_o)
`ifdef PDM_TX_UNDERFLOW_CNT_EN
    ,
    .underflow_cnt_o(underflow_cnt_o)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Model: software FIFO plus accumulator, evaluated once per emitted bit.
  logic [15:0] mq[$];
  int unsigned m_acc;
  logic [15:0] m_cur;
  int          m_idx;
  bit          m_started;
  int          uf_exp, uf_seen, uf_total;
  int          rises = 0, nbits, cyc = 0, last_rise;
  logic        bitlog [0:511];
  logic        prev_clk, prev_data, prev_uf, en_prev;

  function automatic void model_clear();
    m_acc = 0; m_idx = 0; m_started = 0; nbits = 0; last_rise = 0;
  endfunction

  always @(negedge clk_i) begin
    int unsigned s;
    logic        ok;
    cyc++;
    if (!rst_n_i) begin
      model_clear();
      m_cur = '0;
      prev_clk = 0; prev_data = 0; prev_uf = 0; en_prev = 0; uf_total = 0;
    end else begin
      if (!en_prev) begin
        check("idle_clk", pdm_clk_o, 0);
        check("idle_data", pdm_data_o, 0);
        check("idle_uf", underflow_o, 0);
      end else begin
        if (pdm_data_o !== prev_data) begin
          ok = (prev_clk && !pdm_clk_o) || (nbits == 0 && !pdm_clk_o);
          check("data_change_on_fall", ok, 1);
        end
        if (underflow_o) begin
          check("uf_single_cycle", prev_uf, 0);
          uf_seen++;
          if (uf_total < 255) uf_total++;
        end
        if (pdm_clk_o && !prev_clk) begin
          if (m_idx == 0) begin
            if (mq.size() > 0) m_cur = mq.pop_front();
            else begin
              if (!m_started) m_cur = '0;
              uf_exp++;
            end
            m_started = 1;
          end
          s = m_acc + 32'(m_cur ^ 16'h8000);
          check("pdm_bit", pdm_data_o, 32'(s[16]));
          m_acc = s & 32'h0000FFFF;
          m_idx = (m_idx + 1) % OSR;
          if (nbits > 0) check("pdm_period", cyc - last_rise, 2 * HALF_DIV);
          last_rise = cyc;
          rises++;
          if (nbits < 512) bitlog[nbits] = pdm_data_o;
          nbits++;
        end
        if (!pdm_clk_o && prev_clk) check("pdm_high_time", cyc - last_rise, HALF_DIV);
      end
      if (!enable_i) model_clear();
      prev_clk = pdm_clk_o; prev_data = pdm_data_o; prev_uf = underflow_o;
      en_prev = enable_i;
    end
  end

  task automatic push(input logic [15:0] x);
    int k = 0;
    pcm_data_i = x;
    pcm_valid_i = 1;
    @(negedge clk_i);
    while (!pcm_ready_o && k < 100) begin
      @(negedge clk_i);
      k++;
    end
    check("push_ready", pcm_ready_o, 1);
    @(posedge clk_i); #1;
    pcm_valid_i = 0;
    mq.push_back(x);
  endtask

  task automatic wait_bits(input int n);
    int target = rises + n;
    int k = 0;
    while (rises < target && k < n * 2 * HALF_DIV + 50) begin
      @(negedge clk_i);
      k++;
    end
    check("wait_bits_budget", rises, target);
  endtask

  task automatic start_phase();
    uf_seen = 0;
    uf_exp = 0;
    @(posedge clk_i); #1;
    enable_i = 1;
  endtask

  task automatic stop_phase();
    @(posedge clk_i); #1;
    enable_i = 0;
    @(posedge clk_i); #1;
    check("disable_clk", pdm_clk_o, 0);
    check("disable_data", pdm_data_o, 0);
    repeat (3) @(posedge clk_i);
    #1;
    check("uf_model", uf_seen, uf_exp);
`ifdef PDM_TX_UNDERFLOW_CNT_EN
    check("uf_cnt", underflow_cnt_o, uf_total);
`endif
  endtask

  task automatic check_byte(input string name, input logic [7:0] exp);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = bitlog[i];
    check(name, b, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int ones;
    rst_n_i = 0; enable_i = 0; pcm_valid_i = 0; pcm_data_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_ready", pcm_ready_o, 1);
    check("rst_clk", pdm_clk_o, 0);
    check("rst_data", pdm_data_o, 0);
    check("rst_uf", underflow_o, 0);
    rst_n_i = 1;

    // x=0: alternating bits, clock timing
    push(16'h0000);
    start_phase();
    repeat (HALF_DIV + 1) @(posedge clk_i);
    #1 check("first_rise_low", pdm_clk_o, 0);
    @(posedge clk_i);
    #1 check("first_rise_high", pdm_clk_o, 1);
    wait_bits(40);
    check_byte("x0_pattern", 8'hAA);
    check("x0_no_uf", uf_seen, 0);
    stop_phase();

    // full-scale negative then positive, accumulator carried across samples
    push(16'h8000);
    push(16'h7FFF);
    start_phase();
    wait_bits(140);
    ones = 0;
    for (int i = 0; i < 64; i++) ones += int'(bitlog[i]);
    check("neg_fs_ones", ones, 0);
    check("pos_fs_bit64", bitlog[64], 0);
    ones = 0;
    for (int i = 65; i < 128; i++) ones += int'(bitlog[i]);
    check("pos_fs_ones", ones, 63);
    check("fs_uf", uf_seen, 1);
    stop_phase();

    // backpressure with enable low, ready returns after LOAD pop
    push(16'h1234);
    push(16'h0000);
    push(16'hF000);
    push(16'h4000);
    @(negedge clk_i);
    check("full_ready", pcm_ready_o, 0);
    pcm_data_i = 16'h2000;
    pcm_valid_i = 1;
    repeat (3) @(negedge clk_i);
    check("stall_ready", pcm_ready_o, 0);
    start_phase();
    @(negedge clk_i);
    check("ready_idle", pcm_ready_o, 0);
    @(negedge clk_i);
    check("ready_load", pcm_ready_o, 0);
    @(negedge clk_i);
    check("ready_after_pop", pcm_ready_o, 1);
    @(posedge clk_i); #1;
    pcm_valid_i = 0;
    mq.push_back(16'h2000);
    wait_bits(340);
    check("bp_uf", uf_seen, 1);
    stop_phase();

    // drop enable mid-sample; re-enable starts the next FIFO sample from acc=0
    push(16'h4000);
    push(16'h0000);
    start_phase();
    wait_bits(20);
    check_byte("x4000_pattern", 8'hEE);
    stop_phase();
    start_phase();
    wait_bits(140);
    check_byte("resume_pattern", 8'hAA);
    check("resume_uf", uf_seen, 2);
    stop_phase();

    // underflow-only 0x4000 repeats with a pulse every OSR bits
    push(16'h4000);
    start_phase();
    wait_bits(140);
    check_byte("x4000_repeat", 8'hEE);
    check("x4000_uf", uf_seen, 2);
    stop_phase();

    // async reset mid-RUN clears outputs and FIFO
    push(16'h1000);
    push(16'h2000);
    start_phase();
    wait_bits(10);
    @(posedge clk_i); #3;
    rst_n_i = 0;
    #1;
    check("arst_clk", pdm_clk_o, 0);
    check("arst_data", pdm_data_o, 0);
    check("arst_uf", underflow_o, 0);
    check("arst_ready", pcm_ready_o, 1);
    enable_i = 0;
    mq.delete();
    repeat (3) @(posedge clk_i);
    #1 rst_n_i = 1;
    @(posedge clk_i);
    #1 check("post_rst_ready", pcm_ready_o, 1);
    start_phase();
    wait_bits(20);
    check("post_rst_empty_uf", uf_seen, 1);
    check_byte("post_rst_pattern", 8'hAA);
    stop_phase();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
